// File: rtl/mdr_pkg.sv
// Shared definitions for the MDR unit: opcode encodings used by both the
// control unit and the operation engine, plus the engine state encoding.
package mdr_pkg;

  localparam logic [1:0] MDR_OPC_MUL  = 2'd0;
  localparam logic [1:0] MDR_OPC_DIV  = 2'd1;
  localparam logic [1:0] MDR_OPC_SQRT = 2'd2;
  localparam logic [1:0] MDR_OPC_RSVD = 2'd3;

  typedef enum logic [1:0] {
    OP_MUL  = MDR_OPC_MUL,
    OP_DIV  = MDR_OPC_DIV,
    OP_SQRT = MDR_OPC_SQRT,
    OP_RSVD = MDR_OPC_RSVD
  } mdr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE,
    ST_FAIL,
    ST_HOLD
  } mdr_eng_state_e;

endpackage

// File: rtl/mdr_operand_regs.sv
// X / Y / opcode capture registers. Loads are accepted only while the engine
// is idle so operands cannot change under a running algorithm.
module mdr_operand_regs
  import mdr_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_sync_rst,
  input  logic          capture_en,
  input  logic          load_x,
  input  logic          load_y,
  input  logic          load_op,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] x,
  output logic [DW-1:0] y,
  output mdr_op_e       op
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x  <= '0;
      y  <= '0;
      op <= OP_MUL;
    end else if (enable_sync_rst) begin
      x  <= '0;
      y  <= '0;
      op <= OP_MUL;
    end else if (capture_en) begin
      if (load_x)  x  <= data_in;
      if (load_y)  y  <= data_in;
      if (load_op) op <= mdr_op_e'(data_in[1:0]);
    end
  end

endmodule

// File: rtl/mdr_operation_engine.sv
// Iterative unsigned MUL / DIV / SQRT engine answering the MDR control unit.
// state | meaning
// IDLE  | accept loads, wait for run request
// BUSY  | one algorithm iteration per edge, down-counter tracks remaining steps
// DONE  | ready pulse, results valid
// FAIL  | error pulse, results cleared
// HOLD  | wait for run request to drop
module mdr_operation_engine
  import mdr_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_sync_rst,
  input  logic          load_x,
  input  logic          load_Y,
  input  logic          load_op,
  input  logic [DW-1:0] data_in,
  input  logic          enable_operacion,
  output logic [DW-1:0] result,
  output logic [DW-1:0] remainder,
  output logic          ready,
  output logic          error
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0]  x, y;
  mdr_op_e        op;
  mdr_eng_state_e state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [DW-1:0]  hi, hi_nxt, lo, lo_nxt, root, root_nxt;
  logic [DW-1:0]  result_nxt, remainder_nxt;

  logic [DW:0]    mul_sum;
  logic [DW:0]    div_shift;
  logic           div_ge;
  logic [DW+1:0]  sq_shift, sq_trial;
  logic           sq_ge;

  mdr_operand_regs #(.DW(DW)) u_operand_regs (
    .clk             (clk),
    .rst             (rst),
    .enable_sync_rst (enable_sync_rst),
    .capture_en      (state == ST_IDLE),
    .load_x          (load_x),
    .load_y          (load_Y),
    .load_op         (load_op),
    .data_in         (data_in),
    .x               (x),
    .y               (y),
    .op              (op)
  );

  // hi: MUL upper accumulator / DIV and SQRT partial remainder
  // lo: MUL multiplier -> low product / DIV dividend -> quotient / SQRT radicand
  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? x : {DW{1'b0}})};
    div_shift = {hi, lo[DW-1]};
    div_ge    = (div_shift >= {1'b0, y});
    sq_shift  = {hi, lo[DW-1:DW-2]};
    sq_trial  = {root, 2'b01};
    sq_ge     = (sq_shift >= sq_trial);
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_nxt        = hi;
    lo_nxt        = lo;
    root_nxt      = root;
    result_nxt    = result;
    remainder_nxt = remainder;
    case (state)
      ST_IDLE: begin
        if (enable_operacion) begin
          if (op == OP_RSVD || (op == OP_DIV && y == '0)) begin
            state_nxt     = ST_FAIL;
            result_nxt    = '0;
            remainder_nxt = '0;
          end else begin
            state_nxt = ST_BUSY;
            cnt_nxt   = (op == OP_SQRT) ? CW'(DW / 2) : CW'(DW);
            hi_nxt    = '0;
            root_nxt  = '0;
            lo_nxt    = (op == OP_MUL) ? y : x;
          end
        end
      end
      ST_BUSY: begin
        if (!enable_operacion) begin
          state_nxt = ST_IDLE;
        end else begin
          case (op)
            OP_MUL: begin
              hi_nxt = mul_sum[DW:1];
              lo_nxt = {mul_sum[0], lo[DW-1:1]};
            end
            OP_DIV: begin
              hi_nxt = div_ge ? DW'(div_shift - {1'b0, y}) : div_shift[DW-1:0];
              lo_nxt = {lo[DW-2:0], div_ge};
            end
            OP_SQRT: begin
              hi_nxt   = sq_ge ? DW'(sq_shift - sq_trial) : DW'(sq_shift);
              lo_nxt   = {lo[DW-3:0], 2'b00};
              root_nxt = {root[DW-2:0], sq_ge};
            end
            default: ;
          endcase
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (op == OP_MUL && hi_nxt != '0) begin
              state_nxt     = ST_FAIL;
              result_nxt    = '0;
              remainder_nxt = '0;
            end else begin
              state_nxt     = ST_DONE;
              result_nxt    = (op == OP_SQRT) ? root_nxt : lo_nxt;
              remainder_nxt = (op == OP_MUL) ? '0 : hi_nxt;
            end
          end
        end
      end
      ST_DONE, ST_FAIL: state_nxt = ST_HOLD;
      ST_HOLD: if (!enable_operacion) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      root      <= '0;
      result    <= '0;
      remainder <= '0;
    end else if (enable_sync_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      root      <= '0;
      result    <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      root      <= root_nxt;
      result    <= result_nxt;
      remainder <= remainder_nxt;
    end
  end

  assign ready = (state == ST_DONE);
  assign error = (state == ST_FAIL);

endmodule

// File: tb/tb_mdr_operation_engine.sv
// Directed bench for mdr_operation_engine with a queue of expected responses.
module tb_mdr_operation_engine;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable_sync_rst = 1'b0;
  logic          load_x = 1'b0;
  logic          load_Y = 1'b0;
  logic          load_op = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          enable_operacion = 1'b0;
  logic [DW-1:0] result, remainder;
  logic          ready, error;

  mdr_operation_engine #(.DW(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_sync_rst  (enable_sync_rst),
    .load_x           (load_x),
    .load_Y           (load_Y),
    .load_op          (load_op),
    .data_in          (data_in),
    .enable_operacion (enable_operacion),
    .result           (result),
    .remainder        (remainder),
    .ready            (ready),
    .error            (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
    logic          err;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic load_all(input logic [DW-1:0] xv, input logic [DW-1:0] yv, input logic [1:0] opv);
    @(negedge clk); load_x = 1'b1; data_in = xv;
    @(negedge clk); load_x = 1'b0; load_Y = 1'b1; data_in = yv;
    @(negedge clk); load_Y = 1'b0; load_op = 1'b1; data_in = {{(DW-2){1'b0}}, opv};
    @(negedge clk); load_op = 1'b0; data_in = '0;
  endtask

  // Raise the run request, wait for a pulse, score it, then check quiet hold.
  task automatic run_op(input string tag, input logic [DW-1:0] er, input logic [DW-1:0] erm,
                        input logic eerr, input int elat, input int hold_extra, input bit poke);
    exp_t e;
    bit   got = 0;
    bit   extra = 0;
    int   k = 0;
    exp_q.push_back('{tag, er, erm, eerr, elat});
    enable_operacion = 1'b1;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      load_x  = poke && (k == 3);
      data_in = (poke && (k == 3)) ? 16'hFFFF : '0;
      if (ready || error) got = 1;
    end
    load_x = 1'b0;
    data_in = '0;
    chk({tag, " pulse_seen"}, got, 1);
    e = exp_q.pop_front();
    if (got) begin
      chk({tag, " latency"}, k - 1, e.lat);
      chk({tag, " ready_error"}, {ready, error}, {~e.err, e.err});
      chk({tag, " result"}, result, e.res);
      chk({tag, " remainder"}, remainder, e.rem);
    end
    for (int i = 0; i <= hold_extra; i++) begin
      @(negedge clk);
      if (ready || error) extra = 1;
    end
    chk({tag, " no_second_pulse"}, extra, 0);
    enable_operacion = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit seen;

    #3;
    chk("reset outputs", {result, remainder, ready, error}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    load_all(16'd7, 16'd9, 2'd0);
    run_op("mul_7x9", 16'd63, 16'd0, 1'b0, 16, 0, 0);

    load_all(16'd100, 16'd7, 2'd1);
    run_op("div_100_7", 16'd14, 16'd2, 1'b0, 16, 0, 0);

    load_all(16'd1000, 16'd0, 2'd2);
    run_op("sqrt_1000", 16'd31, 16'd39, 1'b0, 8, 0, 0);

    load_all(16'd65535, 16'd1234, 2'd2);
    run_op("sqrt_65535", 16'd255, 16'd510, 1'b0, 8, 0, 0);

    // abort a DIV after edge E0+5
    load_all(16'd50, 16'd3, 2'd1);
    enable_operacion = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready || error) seen = 1;
    end
    enable_operacion = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ready || error) seen = 1;
    end
    chk("abort no_pulse", seen, 0);
    chk("abort result_kept", {result, remainder}, {16'd255, 16'd510});

    load_all(16'd5, 16'd0, 2'd1);
    run_op("div_by_zero", 16'd0, 16'd0, 1'b1, 0, 0, 0);

    load_all(16'd5, 16'd3, 2'd3);
    run_op("reserved_op", 16'd0, 16'd0, 1'b1, 0, 0, 0);

    load_all(16'd300, 16'd300, 2'd0);
    run_op("mul_overflow", 16'd0, 16'd0, 1'b1, 16, 10, 0);

    load_all(16'd2, 16'd2, 2'd0);
    run_op("mul_2x2", 16'd4, 16'd0, 1'b0, 16, 0, 0);

    // async reset in the middle of a MUL
    load_all(16'd3, 16'd5, 2'd0);
    enable_operacion = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset outputs", {result, remainder, ready, error}, 0);
    enable_operacion = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // X load attempted while BUSY must be ignored
    load_all(16'd3, 16'd4, 2'd0);
    run_op("mul_3x4", 16'd12, 16'd0, 1'b0, 16, 0, 1);

    @(negedge clk);
    enable_sync_rst = 1'b1;
    @(negedge clk);
    enable_sync_rst = 1'b0;
    chk("sync_clear result", {result, remainder}, 0);

    chk("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdr_operation_engine.md
# mdr_operation_engine

Iterative unsigned multiply / divide / square-root datapath for the MDR unit. Sits beside the MDR control unit as the responder on its operation interface: captures X, Y and opcode under the control unit's load strobes, runs the selected algorithm when `enable_operacion` is held high, and answers with a one-cycle `ready` or `error` indication that the control unit's PROCESS state waits on.

## Interface
- `DW`, 16: operand/result width; must be even and ≥ 4.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `enable_sync_rst`  in  1  synchronous clear of all registers, state to IDLE.
- `load_x`  in  1  capture `data_in` into X.
- `load_Y`  in  1  capture `data_in` into Y.
- `load_op`  in  1  capture `data_in[1:0]` into opcode.
- `data_in`  in  DW  operand / opcode bus.
- `enable_operacion`  in  1  run request, held high for the whole operation.
- `result`  out  DW  product, quotient or integer root.
- `remainder`  out  DW  division remainder or X − root²; 0 for MUL.
- `ready`  out  1  one-cycle pulse: successful completion.
- `error`  out  1  one-cycle pulse: failed operation.

## Operation
- Opcodes: MUL=0, DIV=1, SQRT=2, 3=reserved.
- Priority: `rst` low > `enable_sync_rst` > everything else.
- Loads are honoured only in IDLE; every edge with a load strobe high overwrites its register (last value wins). Multiple strobes may be high simultaneously; each register captures independently.
- States: IDLE, BUSY, DONE, FAIL, HOLD.
- IDLE → FAIL if `enable_operacion`=1 and (opcode=3, or DIV with Y=0).
- IDLE → BUSY if `enable_operacion`=1 otherwise; iteration counter loaded with N (N=DW for MUL/DIV, DW/2 for SQRT).
- BUSY: one iteration per edge. MUL is shift-add with a 2·DW accumulator. DIV is restoring (quotient/remainder). SQRT is digit-by-digit, two bits of X per step, Y ignored.
- BUSY → DONE after the Nth iteration; `result`/`remainder` registered on that edge.
- BUSY → FAIL after the Nth iteration if MUL and product[2·DW−1:DW] ≠ 0 (overflow).
- BUSY → IDLE if `enable_operacion` falls (abort). No pulse; `result`/`remainder` keep their previous values.
- DONE/FAIL → HOLD after one cycle. HOLD → IDLE when `enable_operacion`=0. No second pulse while the request stays high.
- On entry to FAIL, `result` and `remainder` are cleared to 0.
- `ready` = (state==DONE) and `error` = (state==FAIL); both are Moore outputs, never high together.
- Reset values: state IDLE; X, Y, opcode, `result`, `remainder` = 0; `ready`, `error` = 0.

## Timing
- E0 is the edge on which IDLE samples `enable_operacion`=1.
- Immediate error (reserved op, divide by zero): `error` high for the cycle after E0.
- Normal completion: `ready` high for the cycle after edge E0+N. MUL/DIV take 16 edges at DW=16; SQRT takes 8.
- MUL overflow: `error` high for the cycle after E0+N.
- `result`/`remainder` are valid from the cycle `ready` rises and hold until the next completion, FAIL, sync clear or reset.
- Async reset mid-BUSY: outputs are 0 immediately; no pulse is generated.
- `enable_sync_rst` mid-BUSY: takes effect at the next edge with the same effect as reset.

## Structure
- `mdr_pkg` holds:
  - `mdr_op_e` (2-bit opcode enum)
  - `mdr_eng_state_e` (engine state enum)
  - opcode constants shared with the control unit
- Sub-module `mdr_operand_regs` holds the X/Y/opcode registers with load/clear and IDLE gating. The algorithm datapath and FSM stay in `mdr_operation_engine`.

## Test plan
- MUL: X=7, Y=9, op=0, DW=16 → `ready` 1 cycle after E0+16; `result`=63, `remainder`=0; `error` stays 0.
- DIV: X=100, Y=7, op=1 → `ready` after E0+16; `result`=14, `remainder`=2.
- SQRT: X=1000, op=2 → `ready` after E0+8; `result`=31, `remainder`=39. Repeat with X=65535 → `result`=255, `remainder`=510.
- Immediate errors: DIV with X=5, Y=0 → `error` in the cycle after E0, `result`=0. Op=3 gives the same response. No `ready` in either case.
- MUL overflow: X=300, Y=300 → `error` after E0+16, `result`=0. `enable_operacion` held high 10 more cycles → no further pulses.
- Abort and reset: drop `enable_operacion` at E0+5 of a DIV → IDLE, no pulse, `result` unchanged. Pull `rst` low mid-BUSY → all outputs 0 at once. A following MUL 3×4 completes normally with `result`=12.
